// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter.
// Optional feature macro: RAM_ARBITER_ROUND_ROBIN_EN (see ram_arb_picker).
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_FETCH = 1'b0;
    localparam port_idx_t PORT_DATA  = 1'b1;

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational winner selection between the fetch and data requesters.
// RAM_ARBITER_ROUND_ROBIN_EN: round-robin on ties; otherwise fixed priority to the data port.
module ram_arb_picker
    import ram_arbiter_pkg::*;
(
    input  logic      valid0,
    input  logic      valid1,
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    input  port_idx_t last_grant,
`endif
    output logic      any_valid,
    output port_idx_t winner
);

    always_comb begin
        any_valid = valid0 | valid1;
        winner    = PORT_FETCH;
        if (valid0 && valid1) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            winner = (last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
`else
            winner = PORT_DATA;
`endif
        end else if (valid1) begin
            winner = PORT_DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter sequencing setup/strobe/capture accesses to an asynchronous RAM.
// RAM_ARBITER_ROUND_ROBIN_EN selects round-robin tie-breaking (default: data port wins ties).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [DATA_BITS-1:0] req0_wdata,
    output logic                 done0,
    output logic [DATA_BITS-1:0] rdata0,
    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [DATA_BITS-1:0] req1_wdata,
    output logic                 done1,
    output logic [DATA_BITS-1:0] rdata1,
    output logic [ADDR_BITS-1:0] ram_address,
    inout  logic [DATA_BITS-1:0] ram_data,
    output logic                 ram_out_en,
    output logic                 ram_write_en
);

    arb_state_t           state;
    port_idx_t            grant;
    port_idx_t            winner;
    logic                 any_valid;
    logic                 we_l;
    logic [DATA_BITS-1:0] wdata_l;
    logic                 drive_en;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    port_idx_t            last_grant;
`endif

    ram_arb_picker u_picker (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .any_valid  (any_valid),
        .winner     (winner)
    );

    assign ram_data = drive_en ? wdata_l : 'z;

    // ram_address doubles as the latched request address; it is held through DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= PORT_FETCH;
            we_l         <= 1'b0;
            wdata_l      <= '0;
            drive_en     <= 1'b0;
            ram_address  <= '0;
            ram_out_en   <= 1'b0;
            ram_write_en <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            last_grant   <= PORT_FETCH;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state <= SETUP;
                        grant <= winner;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                        last_grant <= winner;
`endif
                        if (winner == PORT_DATA) begin
                            we_l        <= req1_we;
                            ram_address <= req1_addr;
                            wdata_l     <= req1_wdata;
                            drive_en    <= req1_we;
                            ram_out_en  <= ~req1_we;
                        end else begin
                            we_l        <= req0_we;
                            ram_address <= req0_addr;
                            wdata_l     <= req0_wdata;
                            drive_en    <= req0_we;
                            ram_out_en  <= ~req0_we;
                        end
                    end
                end
                SETUP: begin
                    state        <= STROBE;
                    ram_write_en <= we_l;
                end
                STROBE: begin
                    state        <= DONE;
                    ram_write_en <= 1'b0;
                    ram_out_en   <= 1'b0;
                    if (grant == PORT_DATA) begin
                        done1 <= 1'b1;
                        if (!we_l) rdata1 <= ram_data;
                    end else begin
                        done0 <= 1'b1;
                        if (!we_l) rdata0 <= ram_data;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done0    <= 1'b0;
                    done1    <= 1'b0;
                    drive_en <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural asynchronous RAM on the shared bus.
// Expected grant order follows RAM_ARBITER_ROUND_ROBIN_EN when defined.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req0_we = 1'b0;
    logic [3:0] req0_addr = '0;
    logic [7:0] req0_wdata = '0;
    logic       req1_valid = 1'b0, req1_we = 1'b0;
    logic [3:0] req1_addr = '0;
    logic [7:0] req1_wdata = '0;
    logic       done0, done1, ram_out_en, ram_write_en;
    logic [7:0] rdata0, rdata1;
    logic [3:0] ram_address;
    wire  [7:0] ram_data;

    ram_arbiter #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .done0(done0), .rdata0(rdata0),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .done1(done1), .rdata1(rdata1),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_out_en(ram_out_en), .ram_write_en(ram_write_en)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: drives the bus while out_en, captures at the end of the write strobe.
    logic [7:0] mem [16];
    logic       pl_en = 1'b0;
    logic [3:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    assign ram_data = ram_out_en ? mem[ram_address] : 'z;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_write_en) mem[ram_address] <= ram_data;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;
    exp_t        sb[$];
    logic [7:0]  last_rd [2];
    int          checks = 0;
    int          failures = 0;
    int unsigned wr_cnt = 0, wr_cyc = 0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bus discipline and scoreboard consumption, every cycle away from the clock edge.
    initial forever begin
        @(negedge clk);
        check_eq("excl_oe_we", {31'b0, ram_out_en & ram_write_en}, 0);
        check_eq("bus_z_on_read", {31'b0, ram_out_en & dut.drive_en}, 0);
        if (dut.state == IDLE) check_eq("bus_z_idle", {31'b0, dut.drive_en}, 0);
        if (ram_write_en) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_addr = ram_address;
            wr_data = ram_data;
        end
        if (done0 || done1) begin
            check_eq("done_exclusive", {31'b0, done0 & done1}, 0);
            if (sb.size() == 0) begin
                check_eq("done_spurious", {30'b0, done1, done0}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_port", {31'b0, done1}, {31'b0, e.port});
                check_eq("done_cycle", cyc, e.at);
                check_eq("rdata", e.port ? rdata1 : rdata0, e.we ? last_rd[e.port] : e.data);
                if (!e.we) last_rd[e.port] = e.data;
            end
        end
    end

    task automatic set_req(input bit p, input bit v, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (p) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end
    endtask

    task automatic push_exp(input bit p, input bit we, input logic [7:0] d, input int unsigned at);
        exp_t e;
        e.port = p; e.we = we; e.data = d; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? done1 : done0) && n < 30);
        check_eq(p ? "wait_done1" : "wait_done0", {31'b0, p ? done1 : done0}, 1);
    endtask

    task automatic wait_any_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done0 || done1) && n < 30);
        check_eq("wait_any_done", {31'b0, done0 | done1}, 1);
    endtask

    task automatic access(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp_d, output int unsigned c0);
        @(negedge clk);
        c0 = cyc;
        set_req(p, 1'b1, we, a, d);
        push_exp(p, we, exp_d, c0 + 3);
        wait_done(p);
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        check_eq("rst_done", {30'b0, done1, done0}, 0);
        check_eq("rst_rdata0", rdata0, 0);
        check_eq("rst_rdata1", rdata1, 0);
        check_eq("rst_strobes", {30'b0, ram_out_en, ram_write_en}, 0);
        check_eq("rst_addr", ram_address, 0);
        check_eq("rst_bus_z", {31'b0, dut.drive_en}, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c0, c1, base;
        bit          rr_port [4];
        logic [7:0]  b2b [4];

        apply_reset();
        poke(4'd0, 8'hC0);
        poke(4'd1, 8'h11);
        poke(4'd2, 8'h22);
        poke(4'd6, 8'h60);

        // Single write by data port, then fetch-port read of the same address.
        base = wr_cnt;
        access(1'b1, 1'b1, 4'd3, 8'hA5, 8'h00, c0);
        check_eq("wr_strobe_count", wr_cnt - base, 1);
        check_eq("wr_strobe_cycle", wr_cyc, c0 + 2);
        check_eq("wr_addr", {28'b0, wr_addr}, 3);
        check_eq("wr_data", {24'b0, wr_data}, 32'hA5);
        access(1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, c1);

        // Simultaneous reads from a fresh reset: data port first, fetch 4 cycles later.
        apply_reset();
        @(negedge clk);
        c0 = cyc;
        set_req(1'b0, 1'b1, 1'b0, 4'd1, '0);
        set_req(1'b1, 1'b1, 1'b0, 4'd2, '0);
        push_exp(1'b1, 1'b0, 8'h22, c0 + 3);
        push_exp(1'b0, 1'b0, 8'h11, c0 + 7);
        wait_done(1'b1);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);

        // Repeated tie with both valids held: policy decides the grant sequence.
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        rr_port = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        rr_port = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge clk);
        c0 = cyc;
        set_req(1'b0, 1'b1, 1'b0, 4'd1, '0);
        set_req(1'b1, 1'b1, 1'b0, 4'd2, '0);
        for (int k = 0; k < 4; k++)
            push_exp(rr_port[k], 1'b0, rr_port[k] ? 8'h22 : 8'h11, c0 + 3 + 4 * k);
        for (int k = 0; k < 4; k++) wait_any_done();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);

        // Back-to-back fetch reads of addresses 0..3 with valid held across done.
        b2b = '{8'hC0, 8'h11, 8'h22, 8'hA5};
        @(negedge clk);
        c0 = cyc;
        set_req(1'b0, 1'b1, 1'b0, 4'd0, '0);
        for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b0, b2b[k], c0 + 3 + 4 * k);
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0);
            if (k < 3) set_req(1'b0, 1'b1, 1'b0, 4'(k + 1), '0);
            else set_req(1'b0, 1'b0, 1'b0, '0, '0);
        end

        // Reset asserted during the write strobe; the held request restarts afterwards.
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b1, 4'd7, 8'h3C);
        repeat (2) @(negedge clk);
        check_eq("mid_wr_in_strobe", {31'b0, ram_write_en}, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_we", {31'b0, ram_write_en}, 0);
        check_eq("mid_rst_done", {30'b0, done1, done0}, 0);
        check_eq("mid_rst_idle", {31'b0, dut.state == IDLE}, 1);
        reset_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        c0 = cyc;
        push_exp(1'b1, 1'b1, 8'h00, c0 + 3);
        wait_done(1'b1);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);

        // Request fields change during SETUP; the latched address/data must be used.
        @(negedge clk);
        c0 = cyc;
        set_req(1'b1, 1'b1, 1'b1, 4'd5, 8'h5A);
        push_exp(1'b1, 1'b1, 8'h00, c0 + 3);
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b1, 4'd6, 8'h66);
        wait_done(1'b1);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        check_eq("latched_addr", {28'b0, wr_addr}, 5);
        check_eq("latched_data", {24'b0, wr_data}, 32'h5A);
        access(1'b0, 1'b0, 4'd5, 8'h00, 8'h5A, c1);
        access(1'b0, 1'b0, 4'd6, 8'h00, 8'h60, c1);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single asynchronous-handshake RAM (address / bidirectional data / out_en / write_en) between two requesters.
  - Port 0 is instruction fetch.
  - Port 1 is data load/store.
- Arbitrates, sequences each access (setup, strobe, capture) and returns read data with a one-cycle done pulse.
- Sits between the core's fetch/memory stages and the ram instance.

Parameters:
- ADDR_BITS, 4, RAM address width.
- DATA_BITS, 8, RAM data width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- req0_valid  input  1  port 0 request, held until done0
- req0_we  input  1  port 0: 1=write, 0=read
- req0_addr  input  ADDR_BITS  port 0 address
- req0_wdata  input  DATA_BITS  port 0 write data
- done0  output  1  port 0 access complete, one-cycle pulse
- rdata0  output  DATA_BITS  port 0 read data, valid with done0
- req1_valid, req1_we, req1_addr, req1_wdata, done1, rdata1: same as port 0, for port 1
- ram_address  output  ADDR_BITS  to RAM address
- ram_data  inout  DATA_BITS  RAM data bus; driven only during writes, else high-Z
- ram_out_en  output  1  RAM read enable
- ram_write_en  output  1  RAM write strobe

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at rising edge) produces:
  - state IDLE
  - done0=done1=0, rdata0=rdata1=0
  - ram_out_en=0, ram_write_en=0, ram_address=0, ram_data released (Z)
  - RR pointer = port 1 preferred
  - Reset mid-access aborts immediately; a partially strobed write is not retried.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - No valid: stay in IDLE.
  - Any valid: pick winner (see arbitration), latch its we/addr/wdata and the grant index, go to SETUP.
- SETUP (1 cycle):
  - ram_address = latched addr.
  - Write: ram_data driven with latched wdata.
  - Read: ram_out_en=1.
  - Next state STROBE.
- STROBE (1 cycle):
  - Write: ram_write_en=1, data and address still driven.
  - Read: ram_out_en=1; ram_data sampled into the winner's rdata register at the end of the cycle.
  - Next state DONE.
- DONE (1 cycle):
  - done[grant]=1; rdata valid (read); rdata for a write is unchanged.
  - Address and write data held (hold time); ram_write_en=0, ram_out_en=0.
  - Next state IDLE.
- Latency and throughput:
  - valid seen in IDLE at cycle N → done at cycle N+3.
  - Max throughput: one access per 4 cycles.
- Requester handshake:
  - Holds valid/we/addr/wdata stable until done.
  - May drop valid or present a new request the cycle after done.
  - Requests arriving outside IDLE wait.
  - Inputs changing mid-access are ignored because fields are latched in IDLE.
- Arbitration (default, fixed priority): port 1 wins a simultaneous request; port 0 starvation is accepted.
- Outputs:
  - done and rdata are registered.
  - ram_address, ram_out_en, ram_write_en and the data-bus drive enable are registered from the state.
  - ram_write_en and ram_out_en are never 1 together.
  - ram_data is never driven while ram_out_en=1.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - A last_grant register is updated on each grant.
  - On a simultaneous request, the port not granted last wins.
  - Reset value of last_grant = 0, so port 1 wins the first tie.
- Undefined: fixed priority to port 1; no last_grant register exists.

Decomposition:
- Package ram_arbiter_pkg:
  - enum arb_state_t {IDLE, SETUP, STROBE, DONE}
  - typedef port_idx_t (1 bit)
  - constants PORT_FETCH=0, PORT_DATA=1
- Sub-module ram_arb_picker: combinational winner selection from the two valids and last_grant, with the macro-dependent policy.
- FSM and bus sequencing stay in ram_arbiter.

Test Plan:
- Single write, then read: port 1 writes addr 3 = 0xA5. Required response:
  - ram_write_en high exactly one cycle, in STROBE;
  - done1 at +3;
  - port 0 then reads addr 3 and gets rdata0=0xA5, done0 3 cycles after valid.
- Simultaneous reads: port 0 reads addr 1, port 1 reads addr 2 (preloaded 0x11/0x22). Required response:
  - fixed priority: done1 (0x22) first, then done0 (0x11) 4 cycles later;
  - with RAM_ARBITER_ROUND_ROBIN_EN and a repeated tie: grants alternate 1,0,1,0.
- Back-to-back: port 0 holds valid across done while reading addrs 0..3. Required response:
  - four done0 pulses spaced exactly 4 cycles apart;
  - rdata matches RAM contents.
- Bus discipline checker over all tests:
  - ram_data is Z whenever ram_out_en=1 or the arbiter is idle;
  - ram_write_en and ram_out_en are never both 1.
- Reset mid-write: reset_n low during STROBE. Required response:
  - next edge: ram_write_en=0, state IDLE, no done pulse;
  - a request held after reset release restarts from SETUP.
- Input change during access: port 1 changes addr from 5 to 6 while in SETUP. Required response: the RAM access uses addr 5.
